// File: rtl/aes_word_io_pkg.sv
// Shared constants for the word-serial AES front/back end.
package aes_io_pkg;
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 4;

  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/aes_word_io_if.sv
// Input and output valid/ready word streams of aes_word_io.
interface aes_word_io_if;
  import aes_io_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  logic  in_is_key;
  logic  out_valid;
  logic  out_ready;
  word_t out_data;

  modport master (
    output in_valid, in_data, in_is_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_is_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_word_io_aes.sv
// Combinational AES-128 encryption core: key schedule plus ten rounds.
module AES (
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  output logic [127:0] state_out,
  output logic [127:0] key_out
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] m;
    p = '0;
    x = a;
    m = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = xtime(x);
      m = m >> 1;
    end
    return p;
  endfunction

  // S-box as the GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte 0 is the MSB of each 128-bit value; round key is expanded in place.
  always_comb begin
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   k [16];
    logic [7:0]   rcon;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] sv, kv;
    sv = state_in;
    kv = key_in;
    for (int unsigned i = 0; i < 16; i++) begin
      k[4'(i)] = kv[127:120];
      s[4'(i)] = sv[127:120] ^ kv[127:120];
      sv = sv << 8;
      kv = kv << 8;
    end
    rcon = 8'h01;
    for (int unsigned r = 1; r <= 10; r++) begin
      k[0] = k[0] ^ sbox(k[13]) ^ rcon;
      k[1] = k[1] ^ sbox(k[14]);
      k[2] = k[2] ^ sbox(k[15]);
      k[3] = k[3] ^ sbox(k[12]);
      for (int unsigned i = 4; i < 16; i++) k[4'(i)] = k[4'(i)] ^ k[4'(i - 4)];
      rcon = xtime(rcon);
      // SubBytes and ShiftRows: row i%4 rotates left by its row number
      for (int unsigned i = 0; i < 16; i++) t[4'(i)] = sbox(s[4'(i + 4 * (i % 4))]);
      for (int unsigned c = 0; c < 4; c++) begin
        a0 = t[4'(4 * c)];
        a1 = t[4'(4 * c + 1)];
        a2 = t[4'(4 * c + 2)];
        a3 = t[4'(4 * c + 3)];
        if (r != 10) begin
          s[4'(4 * c)]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4'(4 * c + 1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4'(4 * c + 2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4'(4 * c + 3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end else begin
          s[4'(4 * c)]     = a0;
          s[4'(4 * c + 1)] = a1;
          s[4'(4 * c + 2)] = a2;
          s[4'(4 * c + 3)] = a3;
        end
      end
      for (int unsigned i = 0; i < 16; i++) s[4'(i)] = s[4'(i)] ^ k[4'(i)];
    end
    sv = '0;
    kv = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sv = {sv[119:0], s[4'(i)]};
      kv = {kv[119:0], k[4'(i)]};
    end
    state_out = sv;
    key_out   = kv;
  end
endmodule

// File: rtl/aes_word_io.sv
// Word-serial loader/unloader around the combinational AES core.
module aes_word_io
  import aes_io_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  aes_word_io_if.slave  io,
  output logic [127:0]  last_key,
  output logic          busy
);
  logic [1:0]   state;
  logic [1:0]   kcnt;
  logic [1:0]   scnt;
  logic [1:0]   ocnt;
  logic [3:0]   settle;
  word_t        key_q [BLOCK_WORDS];
  word_t        st_q  [BLOCK_WORDS];
  word_t        ct_q  [BLOCK_WORDS];
  logic [127:0] core_state;
  logic [127:0] core_key;
  logic         in_fire;
  logic         out_fire;

  assign io.in_ready  = (state == LOAD);
  assign io.out_valid = (state == DRAIN);
  assign io.out_data  = ct_q[ocnt];
  assign busy         = (state != LOAD);
  assign in_fire      = io.in_valid & io.in_ready;
  assign out_fire     = io.out_valid & io.out_ready;

  AES u_aes (
    .state_in  ({st_q[0], st_q[1], st_q[2], st_q[3]}),
    .key_in    ({key_q[0], key_q[1], key_q[2], key_q[3]}),
    .state_out (core_state),
    .key_out   (core_key)
  );

  // Load words, time the core's multicycle settle window, then drain ciphertext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      kcnt     <= '0;
      scnt     <= '0;
      ocnt     <= '0;
      settle   <= '0;
      key_q    <= '{default: '0};
      st_q     <= '{default: '0};
      ct_q     <= '{default: '0};
      last_key <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (io.in_is_key) begin
              key_q[kcnt] <= io.in_data;
              kcnt        <= kcnt + 2'd1;
            end else begin
              st_q[scnt] <= io.in_data;
              scnt       <= scnt + 2'd1;
              if (scnt == 2'd3) begin
                state  <= RUN;
                settle <= SETTLE_CYCLES[3:0];
              end
            end
          end
        end
        RUN: begin
          if (settle == 4'd1) begin
            ct_q[0]  <= core_state[127:96];
            ct_q[1]  <= core_state[95:64];
            ct_q[2]  <= core_state[63:32];
            ct_q[3]  <= core_state[31:0];
            last_key <= core_key;
            ocnt     <= '0;
            state    <= DRAIN;
          end else begin
            settle <= settle - 4'd1;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            ocnt <= ocnt + 2'd1;
            if (ocnt == 2'd3) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_word_io.sv
// Directed bench for aes_word_io with SETTLE_CYCLES = 3 and an independent AES model.
module tb_aes_word_io;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] FIPS_LK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] last_key;
  logic         busy;
  int unsigned  cyc = 0;
  int unsigned  hs_cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic [7:0]   sbox_tab [256];

  aes_word_io_if bus ();

  aes_word_io #(.SETTLE_CYCLES(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (bus),
    .last_key (last_key),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, aa, bb;
    acc = 8'h00;
    aa  = a;
    bb  = b;
    while (bb != 8'h00) begin
      if (bb[0]) acc ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb, y, cc;
    cc = 8'h63;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int yy = 1; yy < 256; yy++)
        if (gf_mul(xb, yy[7:0]) == 8'h01) inv = yy[7:0];
      for (int b = 0; b < 8; b++)
        y[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^
               inv[(b + 7) % 8] ^ cc[b];
      sbox_tab[x] = y;
    end
  endtask

  task automatic aes_ref(input logic [127:0] key, input logic [127:0] pt,
                         output logic [127:0] ct, output logic [127:0] lk);
    logic [31:0] w [44];
    logic [7:0]  m [4][4];
    logic [7:0]  n [4][4];
    logic [31:0] tw;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i - 1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox_tab[tw[31:24]], sbox_tab[tw[23:16]], sbox_tab[tw[15:8]], sbox_tab[tw[7:0]]};
        tw[31:24] = tw[31:24] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tw;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = pt[127 - 32 * c - 8 * r -: 8] ^ w[c][31 - 8 * r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) n[r][c] = sbox_tab[m[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            m[r][c] = gf_mul(8'h02, n[r][c]) ^ gf_mul(8'h03, n[(r + 1) % 4][c]) ^
                      n[(r + 2) % 4][c] ^ n[(r + 3) % 4][c];
          else
            m[r][c] = n[r][c];
          m[r][c] = m[r][c] ^ w[4 * rnd + c][31 - 8 * r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) ct[127 - 32 * c - 8 * r -: 8] = m[r][c];
    lk = {w[40], w[41], w[42], w[43]};
  endtask

  task automatic send(input logic [31:0] d, input logic k);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_is_key = k;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 128'd0, 128'd1);
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_words(input logic [127:0] v, input logic k);
    for (int i = 0; i < 4; i++) send(v[127 - 32 * i -: 32], k);
  endtask

  task automatic recv_word(output logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("out_valid_timeout", 128'd0, 128'd1);
    bus.out_ready = 1'b1;
    d = bus.out_data;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic expect_words(input string tag, input logic [127:0] exp, input int nwords);
    logic [31:0] d;
    for (int w = 0; w < nwords; w++) begin
      recv_word(d);
      chk($sformatf("%s_w%0d", tag, w), d, exp[127 - 32 * w -: 32]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_last_key"}, last_key, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    logic [127:0] exp_ct, exp_lk, zero_lk, dummy;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_is_key = 1'b0;
    bus.out_ready = 1'b0;
    build_sbox();

    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", bus.in_ready, 1);

    // FIPS-197 appendix B
    send_words(FIPS_KEY, 1'b1);
    send_words(FIPS_PT, 1'b0);
    @(negedge clk);
    chk("run_busy", busy, 1);
    chk("run_in_ready", bus.in_ready, 0);
    chk("run_out_valid", bus.out_valid, 0);
    expect_words("fips_ct", FIPS_CT, 4);
    chk("fips_last_key", last_key, FIPS_LK);

    // key reuse with backpressure: 5 low cycles, then ready every other cycle
    aes_ref(FIPS_KEY, C1_PT, exp_ct, exp_lk);
    send_words(C1_PT, 1'b0);
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("bp_out_valid_timeout", 128'd0, 128'd1);
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < ((w == 0) ? 5 : 1); j++) begin
        chk($sformatf("bp_hold_valid_w%0d", w), bus.out_valid, 1);
        chk($sformatf("bp_hold_data_w%0d", w), bus.out_data, exp_ct[127 - 32 * w -: 32]);
        chk($sformatf("bp_hold_in_ready_w%0d", w), bus.in_ready, 0);
        @(negedge clk);
      end
      bus.out_ready = 1'b1;
      chk($sformatf("bp_take_data_w%0d", w), bus.out_data, exp_ct[127 - 32 * w -: 32]);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
    end
    chk("bp_done_out_valid", bus.out_valid, 0);
    chk("bp_done_in_ready", bus.in_ready, 1);
    chk("reuse_last_key", last_key, FIPS_LK);

    // interleaved key load, latency check
    send(C1_PT[127:96], 1'b0);
    send(C1_PT[95:64], 1'b0);
    send_words(C1_KEY, 1'b1);
    send(C1_PT[63:32], 1'b0);
    send(C1_PT[31:0], 1'b0);
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("interleave_latency", cyc - hs_cyc, 4);
    expect_words("interleave_ct", C1_CT, 4);

    // reset while in RUN
    send_words(128'd0, 1'b0);
    @(negedge clk);
    chk("pre_reset_run_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_run");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("after_reset_run_out_valid", bus.out_valid, 0);

    // reset while in DRAIN after two words, with a key loaded
    send_words(FIPS_KEY, 1'b1);
    send_words(FIPS_PT, 1'b0);
    expect_words("drain_part", FIPS_CT, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_drain");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("after_reset_drain_out_valid", bus.out_valid, 0);

    // next block with no key: all-zero key
    aes_ref(128'd0, 128'd0, dummy, zero_lk);
    send_words(128'd0, 1'b0);
    expect_words("zero_key_ct", ZERO_CT, 4);
    chk("zero_key_last_key", last_key, zero_lk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
